// File: rtl/vtc_pixel_fetch.sv
`timescale 1ns/1ps
// Pixel fetch behind the video timing generator: pulls one FIFO pixel per active de cycle and
// emits sync/de/rgb with a fixed two-clock latency, blanking to FILL_COLOR after an underflow.
module vtc_pixel_fetch #(
  parameter int unsigned       DATA_W     = 24,
  parameter bit                H_POLARITY = 1'b0,
  parameter bit                V_POLARITY = 1'b0,
  parameter logic [DATA_W-1:0] FILL_COLOR = DATA_W'(24'h0000FF),
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  input  logic              err_clr,
  output logic              fifo_rd_en,
  output logic              frame_start,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out,
  output logic [DATA_W-1:0] rgb_out,
  output logic              underflow,
  output logic [CNT_W-1:0]  underflow_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                vsync_d_q;
  logic                vs_edge_c;
  logic                rd_en_c;
  logic                uf_event_c;
  logic                frame_start_q;
  logic                underflow_q, underflow_d;
  logic [CNT_W-1:0]    uf_cnt_q, uf_cnt_d;
  logic                hs1_q, vs1_q, de1_q, rd_vld1_q;
  logic                hs2_q, vs2_q, de2_q;
  logic [DATA_W-1:0]   rgb_q, rgb_d;

  assign vs_edge_c = (vsync_in == V_POLARITY) && (vsync_d_q != V_POLARITY);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and read strobe; a vsync edge restarts the frame ahead of any underflow
  always_comb begin
    state_d    = state_q;
    rd_en_c    = 1'b0;
    uf_event_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vs_edge_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        rd_en_c = de_in & ~fifo_empty;
        if (vs_edge_c) begin
          state_d = ST_RUN;
        end else if (de_in && fifo_empty) begin
          state_d    = ST_RESYNC;
          uf_event_c = 1'b1;
        end
      end
      ST_RESYNC: begin
        if (vs_edge_c) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_rd_en = rd_en_c;

  // Sticky flag and saturating counter; a fresh event beats a simultaneous clear
  always_comb begin
    underflow_d = underflow_q;
    uf_cnt_d    = uf_cnt_q;
    if (uf_event_c) begin
      underflow_d = 1'b1;
      if (err_clr) begin
        uf_cnt_d = CNT_W'(1);
      end else if (!(&uf_cnt_q)) begin
        uf_cnt_d = uf_cnt_q + CNT_W'(1);
      end
    end else if (err_clr) begin
      underflow_d = 1'b0;
      uf_cnt_d    = '0;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (de1_q) rgb_d = rd_vld1_q ? fifo_rd_data : FILL_COLOR;
  end

  // Edge detect, status and the two-stage output pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_d_q     <= ~V_POLARITY;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      uf_cnt_q      <= '0;
      hs1_q         <= ~H_POLARITY;
      vs1_q         <= ~V_POLARITY;
      de1_q         <= 1'b0;
      rd_vld1_q     <= 1'b0;
      hs2_q         <= ~H_POLARITY;
      vs2_q         <= ~V_POLARITY;
      de2_q         <= 1'b0;
      rgb_q         <= '0;
    end else begin
      vsync_d_q     <= vsync_in;
      frame_start_q <= vs_edge_c;
      underflow_q   <= underflow_d;
      uf_cnt_q      <= uf_cnt_d;
      hs1_q         <= hsync_in;
      vs1_q         <= vsync_in;
      de1_q         <= de_in;
      rd_vld1_q     <= rd_en_c;
      hs2_q         <= hs1_q;
      vs2_q         <= vs1_q;
      de2_q         <= de1_q;
      rgb_q         <= rgb_d;
    end
  end

  assign frame_start   = frame_start_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = uf_cnt_q;
  assign hsync_out     = hs2_q;
  assign vsync_out     = vs2_q;
  assign de_out        = de2_q;
  assign rgb_out       = rgb_q;

endmodule

// File: tb/tb_vtc_pixel_fetch.sv
`timescale 1ns/1ps
// Scoreboard bench for vtc_pixel_fetch on a miniature 8x4 active / 12x6 total raster.
module tb_vtc_pixel_fetch;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned CNT_W  = 2;
  localparam logic [23:0] FILL   = 24'h0000FF;
  localparam int H_ACT = 8;
  localparam int H_TOT = 12;
  localparam int V_ACT = 4;
  localparam int V_TOT = 6;
  localparam logic [2:0] IDLE3 = 3'b110;

  logic              clk = 1'b0;
  logic              rstn;
  logic              hsync_in, vsync_in, de_in;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty, err_clr;
  logic              fifo_rd_en, frame_start, hsync_out, vsync_out, de_out;
  logic [DATA_W-1:0] rgb_out;
  logic              underflow;
  logic [CNT_W-1:0]  underflow_cnt;

  int checks   = 0;
  int failures = 0;

  logic [23:0] fifo_q[$];
  logic [23:0] exp_pix[$];
  bit          streaming;
  logic        exp_uf;
  logic [1:0]  exp_cnt;
  bit          fs_pend;
  int          exp_n;
  int          rd_cnt;
  int          rst_left;

  vtc_pixel_fetch #(
    .DATA_W(DATA_W), .H_POLARITY(1'b0), .V_POLARITY(1'b0),
    .FILL_COLOR(FILL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .err_clr(err_clr),
    .fifo_rd_en(fifo_rd_en), .frame_start(frame_start),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .rgb_out(rgb_out), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hsync_out"}, 32'(hsync_out), 32'd1);
    chk({tag, "_vsync_out"}, 32'(vsync_out), 32'd1);
    chk({tag, "_de_out"}, 32'(de_out), 32'd0);
    chk({tag, "_rgb_out"}, 32'(rgb_out), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    chk({tag, "_cnt"}, 32'(underflow_cnt), 32'd0);
  endtask

  task automatic refill();
    fifo_q.delete();
    for (int i = 1; i <= 64; i++) fifo_q.push_back(24'(i));
  endtask

  // One pixel clock: drive inputs, predict, check at negedge, then serve the FIFO read
  task automatic step(input int h, input int v, input bit uf, input bit clr, input bit rst);
    bit exp_rd, vs_edge, ev, rd_s;
    if (rst_left > 0) begin
      rst_left--;
      if (rst_left == 0) rstn = 1'b1;
    end
    de_in      = (h < H_ACT) && (v < V_ACT);
    hsync_in   = (h == 9 || h == 10) ? 1'b0 : 1'b1;
    vsync_in   = (v == 5) ? 1'b0 : 1'b1;
    fifo_empty = uf || (fifo_q.size() == 0);
    err_clr    = clr;
    if (rst) begin
      rstn     = 1'b0;
      rst_left = 3;
      #1;
      chk_reset("midline_rst");
    end
    if (!rstn) begin
      streaming = 1'b0;
      exp_uf    = 1'b0;
      exp_cnt   = 2'd0;
      fs_pend   = 1'b0;
    end
    vs_edge = rstn && (v == 5) && (h == 0);
    exp_rd  = streaming && de_in && !fifo_empty;
    if (rstn && de_in) exp_pix.push_back(exp_rd ? 24'(exp_n) : FILL);
    if (exp_rd) exp_n++;
    @(negedge clk);
    rd_s = fifo_rd_en;
    chk("rd_en", 32'(rd_s), 32'(exp_rd));
    chk("frame_start", 32'(frame_start), 32'(fs_pend));
    chk("underflow", 32'(underflow), 32'(exp_uf));
    chk("underflow_cnt", 32'(underflow_cnt), 32'(exp_cnt));
    if (rd_s) rd_cnt++;
    ev = streaming && de_in && fifo_empty && !vs_edge;
    if (ev) begin
      streaming = 1'b0;
      exp_uf    = 1'b1;
      exp_cnt   = clr ? 2'd1 : ((exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1);
    end else if (clr && rstn) begin
      exp_uf  = 1'b0;
      exp_cnt = 2'd0;
    end
    fs_pend = vs_edge;
    if (vs_edge) begin
      streaming = 1'b1;
      exp_n     = 1;
      refill();
    end
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
  endtask

  task automatic run_frame(input int uf_v, input int uf_h, input bit uf_clr,
                           input int clr_v, input int clr_h, input int rst_v, input int rst_h,
                           input bit line_chk, input int exp_reads,
                           input logic exp_uf_end, input logic [1:0] exp_cnt_end);
    rd_cnt = 0;
    for (int v = 0; v < V_TOT; v++) begin
      int line_start;
      line_start = rd_cnt;
      for (int h = 0; h < H_TOT; h++) begin
        bit uf, clr;
        uf  = (v == uf_v) && (h == uf_h);
        clr = (uf && uf_clr) || ((v == clr_v) && (h == clr_h));
        step(h, v, uf, clr, (v == rst_v) && (h == rst_h));
      end
      if (line_chk && v < V_ACT) chk("line_reads", 32'(rd_cnt - line_start), 32'(H_ACT));
    end
    chk("frame_reads", 32'(rd_cnt), 32'(exp_reads));
    chk("frame_underflow", 32'(underflow), 32'(exp_uf_end));
    chk("frame_cnt", 32'(underflow_cnt), 32'(exp_cnt_end));
  endtask

  // Monitor: sync/de delayed two clocks, rgb popped from the scoreboard on each de_out
  initial begin : monitor
    logic [2:0]  h1, h2, cur;
    logic [23:0] e;
    h1 = IDLE3;
    h2 = IDLE3;
    forever begin
      @(negedge clk);
      cur = {hsync_in, vsync_in, de_in};
      if (!rstn) begin
        h1 = IDLE3;
        h2 = IDLE3;
        exp_pix.delete();
      end else begin
        chk("sync_de_out", 32'({hsync_out, vsync_out, de_out}), 32'(h2));
        if (de_out) begin
          if (exp_pix.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pix_extra t=%0t act=%0h exp=none", $time, rgb_out);
          end else begin
            e = exp_pix.pop_front();
            chk("rgb_out", 32'(rgb_out), 32'(e));
          end
        end else begin
          chk("rgb_blank", 32'(rgb_out), 32'd0);
        end
        h2 = h1;
        h1 = cur;
      end
    end
  end

  initial begin
    rstn         = 1'b0;
    hsync_in     = 1'b1;
    vsync_in     = 1'b1;
    de_in        = 1'b0;
    err_clr      = 1'b0;
    fifo_rd_data = '0;
    refill();
    fifo_empty   = 1'b0;
    streaming    = 1'b0;
    exp_uf       = 1'b0;
    exp_cnt      = 2'd0;
    fs_pend      = 1'b0;
    exp_n        = 1;
    rst_left     = 0;
    rd_cnt       = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    //        uf_v uf_h clr  clr_v clr_h rst_v rst_h line reads uf   cnt
    run_frame(-1, -1, 1'b0, -1, -1, -1, -1, 1'b0, 0,  1'b0, 2'd0); // idle: fill only
    run_frame(-1, -1, 1'b0, -1, -1, -1, -1, 1'b1, 32, 1'b0, 2'd0); // full stream
    run_frame( 2,  3, 1'b0, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd1); // underflow
    run_frame( 2,  3, 1'b0, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd2);
    run_frame( 2,  3, 1'b1, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd1); // clear + event
    run_frame(-1, -1, 1'b0,  1,  2, -1, -1, 1'b1, 32, 1'b0, 2'd0); // clear alone
    run_frame( 2,  3, 1'b0, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd1);
    run_frame( 2,  3, 1'b0, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd2);
    run_frame( 2,  3, 1'b0, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd3);
    run_frame( 2,  3, 1'b0, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd3); // saturated
    run_frame( 2,  3, 1'b0, -1, -1, -1, -1, 1'b0, 19, 1'b1, 2'd3);
    run_frame(-1, -1, 1'b0, -1, -1,  1,  4, 1'b0, 12, 1'b0, 2'd0); // mid-line reset
    run_frame(-1, -1, 1'b0, -1, -1, -1, -1, 1'b1, 32, 1'b0, 2'd0); // recovers
    repeat (4) @(posedge clk);
    chk("pix_drain", 32'(exp_pix.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
